// File: rtl/const_div_serial.sv
// Digit-serial unsigned divider by a compile-time constant: CHUNK operand bits per clock,
// MSB chunk first, each step a {remainder, chunk} / DIVISOR table lookup.
module const_div_serial #(
  parameter int WIDTH   = 24,
  parameter int DIVISOR = 47,
  parameter int CHUNK   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_q,
  output logic [$clog2(DIVISOR)-1:0]   out_r
);

  localparam int RW    = $clog2(DIVISOR);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int VW    = RW + CHUNK;
  localparam logic [VW-1:0] DIV_V = VW'(DIVISOR);

  if (((WIDTH % CHUNK) != 0) || (DIVISOR < 2) ||
      ((WIDTH < 31) && (DIVISOR >= (1 << WIDTH)))) begin : g_param_err
    $error("const_div_serial: illegal WIDTH/DIVISOR/CHUNK combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_acc;
  logic [RW-1:0]     r_rem;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_q;
  logic [RW-1:0]     r_r;

  logic [VW-1:0]     w_v;
  logic [CHUNK-1:0]  w_q_chunk;
  logic [RW-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]  w_acc_nxt;
  logic              w_last;

  // One division step; rem < DIVISOR keeps the quotient chunk within CHUNK bits.
  assign w_v       = {r_rem, r_x[WIDTH-1 -: CHUNK]};
  assign w_q_chunk = CHUNK'(w_v / DIV_V);
  assign w_rem_nxt = RW'(w_v % DIV_V);
  assign w_acc_nxt = (r_acc << CHUNK) | WIDTH'(w_q_chunk);
  assign w_last    = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_BUSY;
        else          w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_BUSY;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Results are published only on the final step, so partial quotients never reach out_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= in_x;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_x   <= r_x << CHUNK;
          r_rem <= w_rem_nxt;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_q <= w_acc_nxt;
            r_r <= w_rem_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_q     = r_q;
  assign out_r     = r_r;

endmodule

// File: tb/tb_const_div_serial.sv
// Directed bench for const_div_serial at defaults, plus two parameter overrides
// checked against in_x / D and in_x % D.
module tb_const_div_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default configuration: WIDTH=24, DIVISOR=47, CHUNK=6
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [23:0] in_x = 24'd0, out_q;
  logic [5:0]  out_r;

  // WIDTH=32, DIVISOR=3, CHUNK=4
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid;
  logic [31:0] a_in_x = 32'd0, a_out_q;
  logic [1:0]  a_out_r;

  // WIDTH=24, DIVISOR=47, CHUNK=1
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic [23:0] b_in_x = 24'd0, b_out_q;
  logic [5:0]  b_out_r;

  const_div_serial u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r));

  const_div_serial #(.WIDTH(32), .DIVISOR(3), .CHUNK(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x),
    .out_valid(a_out_valid), .out_ready(1'b1), .out_q(a_out_q), .out_r(a_out_r));

  const_div_serial #(.WIDTH(24), .DIVISOR(47), .CHUNK(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_q(b_out_q), .out_r(b_out_r));

  // Offer x, wait for acceptance, then count cycles (accept cycle = 1) until out_valid.
  task automatic do_op(input logic [23:0] x, output logic [23:0] q, output logic [5:0] r,
                       output int lat);
    int n;
    in_x = x;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    q = out_q;
    r = out_r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 24'd0 || out_r !== 6'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b q=%0d r=%0d ready=%b, expected 0 0 0 0",
               out_valid, out_q, out_r, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [23:0] q; logic [5:0] r; int lat;
    out_ready = 1'b1;
    do_op(24'd1000000, q, r, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL latency: got %0d expected 5", lat);
    end
    checks++;
    if (q !== 24'd21276 || r !== 6'd28) begin
      failures++;
      $display("FAIL basic_1000000: q=%0d r=%0d expected q=21276 r=28", q, r);
    end
  endtask

  task automatic test_boundaries();
    logic [23:0] xs [4] = '{24'd16777215, 24'd0, 24'd46, 24'd47};
    logic [23:0] eq [4] = '{24'd356962, 24'd0, 24'd0, 24'd1};
    logic [5:0]  er [4] = '{6'd1, 6'd0, 6'd46, 6'd0};
    logic [23:0] q; logic [5:0] r; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(xs[i], q, r, lat);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        failures++;
        $display("FAIL boundary x=%0d: q=%0d r=%0d expected q=%0d r=%0d",
                 xs[i], q, r, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] q; logic [5:0] r; int lat; int bad;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(24'd123456, q, r, lat);
    checks++;
    if (q !== 24'd2626 || r !== 6'd34) begin
      failures++;
      $display("FAIL hold_result: q=%0d r=%0d expected q=2626 r=34", q, r);
    end
    in_x = 24'd5;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 24'd2626 || out_r !== 6'd34)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [23:0] q; logic [5:0] r; int lat;
    in_x = 24'd1000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 24'd0 || out_r !== 6'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b q=%0d r=%0d ready=%b expected all 0",
               out_valid, out_q, out_r, in_ready);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_valid: got %b expected 0", out_valid);
      end
    end
    do_op(24'd94, q, r, lat);
    checks++;
    if (q !== 24'd2 || r !== 6'd0 || lat !== 5) begin
      failures++;
      $display("FAIL after_reset_94: q=%0d r=%0d lat=%0d expected q=2 r=0 lat=5", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ops [3] = '{24'd123456, 24'd500, 24'd16777215};
    logic [23:0] eq [3]  = '{24'd2626, 24'd10, 24'd356962};
    logic [5:0]  er [3]  = '{6'd34, 6'd30, 6'd1};
    int t_out [3];
    int ni, no;
    logic acc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    ni = 0;
    no = 0;
    for (int cyc = 0; cyc < 60 && no < 3; cyc++) begin
      in_valid = (ni < 3);
      in_x = ops[(ni < 3) ? ni : 2];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) ni++;
      if (out_valid) begin
        t_out[no] = cyc;
        checks++;
        if (out_q !== eq[no] || out_r !== er[no]) begin
          failures++;
          $display("FAIL b2b_result%0d: q=%0d r=%0d expected q=%0d r=%0d",
                   no, out_q, out_r, eq[no], er[no]);
        end
        no++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (no !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected 3", no);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t_out[i] - t_out[i-1] !== 6) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d cycles expected 6", i, t_out[i] - t_out[i-1]);
        end
      end
    end
  endtask

  task automatic test_override_w32();
    logic [31:0] x, eq; logic [1:0] er; int n;
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? 32'hFFFF_FFFF : $urandom();
      eq = x / 32'd3;
      er = 2'(x % 32'd3);
      a_in_x = x;
      a_in_valid = 1'b1;
      n = 0;
      while (!a_in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      n = 0;
      while (!a_out_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (a_out_valid !== 1'b1 || a_out_q !== eq || a_out_r !== er) begin
        failures++;
        $display("FAIL ovr_w32 x=%0d: valid=%b q=%0d r=%0d expected q=%0d r=%0d",
                 x, a_out_valid, a_out_q, a_out_r, eq, er);
      end
    end
  endtask

  task automatic test_override_c1();
    logic [23:0] x, eq; logic [5:0] er; int n;
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? 24'hFF_FFFF : 24'($urandom());
      eq = x / 24'd47;
      er = 6'(x % 24'd47);
      b_in_x = x;
      b_in_valid = 1'b1;
      n = 0;
      while (!b_in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_q !== eq || b_out_r !== er) begin
        failures++;
        $display("FAIL ovr_c1 x=%0d: valid=%b q=%0d r=%0d expected q=%0d r=%0d",
                 x, b_out_valid, b_out_q, b_out_r, eq, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_override_w32();
    test_override_c1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
